// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

  // Word-index width of the instruction memory (DEPTH = 2**IMEM_ADDR_W words)
  localparam int IMEM_ADDR_W = 7;

  // addi x0,x0,0 -- fed to the core while it is held off
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/ld_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words for the memory write port.
// Latency: word strobe (wr_pend) asserts for one cycle, the cycle after the 4th byte.
// Backpressure: none; accepts one byte per cycle, even while a write is pending.
module ld_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        wr_pend,
  output logic [31:0] wr_dat
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] part_q, part_d;   // bytes 0..2 of the word being assembled
  logic [31:0] wbuf_q, wbuf_d;   // completed word, held for its write cycle
  logic        wr_pend_q, wr_pend_d;

  // Byte placement; the 4th byte completes the word and raises a one-cycle write strobe
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    part_d     = part_q;
    wbuf_d     = wbuf_q;
    wr_pend_d  = 1'b0;
    if (clr) begin
      byte_cnt_d = 2'd0;
    end else if (byte_vld) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    part_d[7:0]   = byte_dat;
        2'd1:    part_d[15:8]  = byte_dat;
        2'd2:    part_d[23:16] = byte_dat;
        default: begin
          wbuf_d    = {byte_dat, part_q};
          wr_pend_d = 1'b1;
        end
      endcase
    end
  end

  // Packer state; reset drops any partial word so it is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      part_q     <= '0;
      wbuf_q     <= '0;
      wr_pend_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      part_q     <= part_d;
      wbuf_q     <= wbuf_d;
      wr_pend_q  <= wr_pend_d;
    end
  end

  assign wr_pend = wr_pend_q;
  assign wr_dat  = wbuf_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Shares the instruction-memory port between a byte-stream boot loader and core fetch.
// Latency: fetch is combinational in RUN; each word is written the cycle after its 4th byte.
// Backpressure: loader sees ready only in LOAD; core is stalled (NOPs) outside RUN.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int          ADDR_W  = IMEM_ADDR_W,
  parameter bit          BOOT_EN = 1'b1,
  parameter logic [31:0] NOP     = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic [7:0]        ld_byte,
  input  logic              ld_byte_valid,
  output logic              ld_byte_ready,
  input  logic [31:0]       core_pc,
  output logic [31:0]       core_instr,
  output logic              core_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              boot_done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam state_e          RST_STATE = BOOT_EN ? IDLE : RUN;

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] word_cnt_q, word_cnt_d;
  logic            boot_done_q, boot_done_d;
  logic            err_q, err_d;
  logic            start_acc, byte_acc, wr_pend;
  logic [31:0]     wbuf;
  logic            pc_hi_unused;

  // A start request is honoured only outside LOAD; bytes only inside it
  assign ld_byte_ready = (state_q == LOAD);
  assign byte_acc      = ld_byte_valid && ld_byte_ready;
  assign start_acc     = ld_start && (state_q != LOAD);

  ld_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .byte_vld (byte_acc),
    .byte_dat (ld_byte),
    .wr_pend  (wr_pend),
    .wr_dat   (wbuf)
  );

  // Next state: length clamp on start, word counting, finish detection, sticky flags
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    boot_done_d = boot_done_q;
    err_d       = err_q;
    if (start_acc) begin
      word_cnt_d  = '0;
      boot_done_d = 1'b0;
      if (ld_len > DEPTH) begin
        len_d = DEPTH;
        err_d = 1'b1;
      end else begin
        len_d = ld_len;
      end
      if (ld_len == '0) begin
        state_d     = RUN;
        boot_done_d = 1'b1;
      end else begin
        state_d = LOAD;
      end
    end else if (state_q == LOAD) begin
      if (wr_pend) word_cnt_d = word_cnt_q + 1'b1;
      // Leave LOAD together with the final write so the core resumes the next cycle
      if (word_cnt_d == len_q) begin
        state_d     = RUN;
        boot_done_d = 1'b1;
      end
    end
    if ((state_q == RUN) && (core_pc[1:0] != 2'b00)) err_d = 1'b1;
  end

  // Control registers; reset abandons any load in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      boot_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      boot_done_q <= boot_done_d;
      err_q       <= err_d;
    end
  end

  // Port mux: a pending loader write owns the port, otherwise the core fetches
  assign mem_we     = wr_pend;
  assign mem_addr   = wr_pend ? word_cnt_q[ADDR_W-1:0] : core_pc[ADDR_W+1:2];
  assign mem_wdata  = wr_pend ? wbuf : '0;
  assign core_stall = (state_q != RUN);
  assign core_instr = core_stall ? NOP : mem_rdata;
  assign boot_done  = boot_done_q;
  assign err        = err_q;

  // Upper PC bits are outside the memory window
  assign pc_hi_unused = ^core_pc[31:ADDR_W+2];

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomised bench for imem_boot_ctrl with a memory model and write scoreboard.
// Latency: checks a 1-cycle stall release after the last write and zero-latency fetch.
// Backpressure: drives the loader only through the valid/ready handshake.
module tb_imem_boot_ctrl;
  import imem_pkg::*;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_len = '0;
  logic [7:0]  ld_byte = '0;
  logic        ld_byte_valid = 1'b0;
  logic        ld_byte_ready;
  logic [31:0] core_pc = '0;
  logic [31:0] core_instr;
  logic        core_stall;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        boot_done;
  logic        err;

  imem_boot_ctrl #(.ADDR_W(7), .BOOT_EN(1'b1), .NOP(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_len(ld_len),
    .ld_byte(ld_byte), .ld_byte_valid(ld_byte_valid), .ld_byte_ready(ld_byte_ready),
    .core_pc(core_pc), .core_instr(core_instr), .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .boot_done(boot_done), .err(err)
  );

  always #5 clk = ~clk;

  // The instruction memory array itself: synchronous write, combinational read
  logic [31:0] mem [128];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  int          wr_seen = 0;
  int          wr_base = 0;
  int          exp_wr = 0;
  logic        exp_err = 1'b0;
  logic [31:0] ref_mem [128];
  logic [7:0]  bytes_q [$];
  wr_t         exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (mem_we) begin
      wr_seen++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(int nb);
    bytes_q.delete();
    for (int i = 0; i < nb; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference model: word i = bytes 4i..4i+3 little-endian, for i < min(len, 128),
  // limited to words whose four bytes are actually offered
  task automatic plan(int len, int nb);
    int n;
    logic [31:0] w;
    n = (len > 128) ? 128 : len;
    if (len > 128) exp_err = 1'b1;
    wr_base = wr_seen;
    exp_wr = 0;
    for (int i = 0; i < n; i++) begin
      if (4 * i + 3 < nb) begin
        w = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
        ref_mem[i] = w;
        exp_q.push_back('{a: i[6:0], d: w});
        exp_wr++;
      end
    end
  endtask

  task automatic start(int len);
    ld_len = len[7:0];
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(int nb, bit gaps);
    int i;
    int budget;
    bit acc;
    i = 0;
    budget = nb * 4 + 100;
    while (i < nb && budget > 0) begin
      ld_byte = bytes_q[i];
      ld_byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      acc = ld_byte_valid && ld_byte_ready;
      tick();
      if (acc) i++;
      budget--;
    end
    ld_byte_valid = 1'b0;
    chk("bytes_accepted", i, nb);
  endtask

  task automatic finish_load();
    int t;
    t = 0;
    @(negedge clk);
    while (core_stall && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("run_reached", 32'(core_stall), 0);
    chk("stall_release_lat", cyc - last_we_cyc, 1);
    chk("sb_empty", exp_q.size(), 0);
    chk("wr_count", wr_seen - wr_base, exp_wr);
    chk("boot_done", 32'(boot_done), 1);
    chk("err", 32'(err), 32'(exp_err));
  endtask

  task automatic fetch(logic [31:0] pc, logic [31:0] exp, string name);
    core_pc = pc;
    @(negedge clk);
    chk(name, core_instr, exp);
    tick();
  endtask

  initial begin
    int len;
    // 1: reset, boot-enabled -> stalled, NOP, idle port
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(core_stall), 1);
    chk("rst_instr", core_instr, 32'h0000_0013);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_boot_done", 32'(boot_done), 0);
    chk("rst_ready", 32'(ld_byte_ready), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_stall", 32'(core_stall), 1);
    chk("idle_ready", 32'(ld_byte_ready), 0);
    tick();

    // 2: two-word boot from a fixed byte stream
    bytes_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    plan(2, 8);
    start(2);
    send(8, 1'b0);
    finish_load();
    tick();
    fetch(32'd4, 32'h0020_0593, "fetch_pc4");
    fetch(32'd0, 32'h0010_0513, "fetch_pc0");

    // 3: oversize length is clamped to the full array and flags err
    fill_random(512);
    plan(200, 512);
    start(200);
    send(512, 1'b0);
    finish_load();
    tick();
    fetch(32'd508, ref_mem[127], "fetch_last_word");

    // 4: reset mid-word abandons the partial word
    fill_random(32);
    plan(8, 23);
    start(8);
    send(23, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 0);
    chk("midrst_ready", 32'(ld_byte_ready), 0);
    chk("midrst_stall", 32'(core_stall), 1);
    chk("midrst_boot_done", 32'(boot_done), 0);
    chk("midrst_err", 32'(err), 0);
    exp_err = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_ready", 32'(ld_byte_ready), 0);
    chk("post_rst_stall", 32'(core_stall), 1);
    chk("post_rst_sb_empty", exp_q.size(), 0);
    chk("post_rst_wr_count", wr_seen - wr_base, exp_wr);
    for (int i = 0; i < 8; i++) chk("mem_intact", mem[i], ref_mem[i]);
    tick();

    // 5: zero-length start goes straight to RUN, then a run-time reload of one word
    start(0);
    @(negedge clk);
    chk("len0_run", 32'(core_stall), 0);
    chk("len0_boot_done", 32'(boot_done), 1);
    tick();
    fetch(32'd8, ref_mem[2], "fetch_pc8");
    fill_random(4);
    plan(1, 4);
    core_pc = 32'd8;
    start(1);
    @(negedge clk);
    chk("reload_stall", 32'(core_stall), 1);
    chk("reload_nop", core_instr, 32'h0000_0013);
    chk("reload_boot_done", 32'(boot_done), 0);
    tick();
    send(4, 1'b0);
    finish_load();
    tick();
    fetch(32'd8, ref_mem[2], "fetch_pc8_after");
    fetch(32'd0, ref_mem[0], "fetch_reloaded");

    // 6: misaligned fetch flags err but still reads word 1; gappy random load
    core_pc = 32'd6;
    @(negedge clk);
    chk("misalign_instr", core_instr, ref_mem[1]);
    tick();
    core_pc = 32'd0;
    @(negedge clk);
    chk("misalign_err", 32'(err), 1);
    exp_err = 1'b1;
    tick();
    len = $urandom_range(3, 40);
    fill_random(4 * len);
    plan(len, 4 * len);
    start(len);
    send(4 * len, 1'b1);
    finish_load();
    tick();
    for (int k = 0; k < 6; k++) begin
      int idx;
      idx = $urandom_range(0, len - 1);
      fetch(32'(idx * 4), ref_mem[idx], "fetch_random");
    end
    chk("err_sticky", 32'(err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
